id_report_arbiter: RTL and testbench

- Shares one identity-report channel among NREQ leaf instances of a parameterised instance tree.
- Each leaf presents its instance value and its two parameter values (p1, p2) on request.
- The arbiter grants leaves round-robin, latches the winner's triple, and presents it on a valid/ready output to a single reporter (display/log sink).
- Lets a multi-level hierarchy report instance identity through one ordered, lossless stream.

---
 rtl/id_report_arbiter.sv | 160 ++++++++++++++++
 tb/tb_id_report_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_report_arbiter.sv
// id_report_arbiter
//
// Several leaf instances share one identity-report channel. Each leaf raises
// req and presents its instance value plus two parameter values. The arbiter
// picks one leaf round-robin, pulses that leaf's gnt for one cycle, latches
// its triple and source index, and holds them on a valid/ready output until
// the reporter accepts. After each accepted report the search pointer moves
// one past the winner. Each report takes at least two cycles: a grant cycle
// and one IDLE cycle after acceptance.

module id_report_arbiter #(
    parameter int NREQ = 4,   // number of requesters, 2..16
    parameter int DW   = 32,  // width of the id, p1 and p2 fields
    parameter int SW   = 2    // source-index width, NREQ <= 2**SW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    input  logic [NREQ*DW-1:0]   id_in,
    input  logic [NREQ*DW-1:0]   p1_in,
    input  logic [NREQ*DW-1:0]   p2_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_id,
    output logic [DW-1:0]        out_p1,
    output logic [DW-1:0]        out_p2,
    output logic [SW-1:0]        out_src,
    output logic                 busy,
    output logic [15:0]          count
);

    // Two-state controller. IDLE waits for a request; HOLD presents the
    // latched report until the sink takes it.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    localparam logic [15:0] CNT_MAX  = 16'hFFFF;
    localparam logic [SW-1:0] LAST_IDX = SW'(NREQ - 1);

    logic [0:0]      state_q, state_d;
    logic [SW-1:0]   ptr_q,   ptr_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   id_q,    id_d;
    logic [DW-1:0]   p1_q,    p1_d;
    logic [DW-1:0]   p2_q,    p2_d;
    logic [SW-1:0]   src_q,   src_d;
    logic [15:0]     count_q, count_d;

    logic            win_found;
    logic [SW-1:0]   win_idx;
    logic [SW-1:0]   ptr_after_src;
    logic [15:0]     count_inc;

    // Round-robin search: first requesting leaf at or after ptr, wrapping at NREQ.
    always_comb begin
        int cand;
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = SW'(cand);
            end
        end
    end

    // Pointer after acceptance wraps at NREQ-1, not at 2**SW.
    assign ptr_after_src = (src_q == LAST_IDX) ? '0 : src_q + 1'b1;

    // Accepted-report counter saturates instead of wrapping.
    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 16'd1;

    // Next-state logic: grant and capture in IDLE, hold and release in HOLD.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        valid_d = valid_q;
        id_d    = id_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        src_d   = src_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    // Data is taken from the inputs in the grant cycle; later
                    // changes on id_in/p1_in/p2_in do not reach the output.
                    id_d    = id_in[win_idx*DW +: DW];
                    p1_d    = p1_in[win_idx*DW +: DW];
                    p2_d    = p2_in[win_idx*DW +: DW];
                    src_d   = win_idx;
                    gnt_d   = NREQ'(1) << win_idx;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // req is ignored here; only the sink handshake matters.
                if (out_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = ptr_after_src;
                    count_d = count_inc;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any report in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            src_q   <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            src_q   <= src_d;
            count_q <= count_d;
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = valid_q;
    assign out_id    = id_q;
    assign out_p1    = p1_q;
    assign out_p2    = p2_q;
    assign out_src   = src_q;
    assign busy      = (state_q == S_HOLD);
    assign count     = count_q;

endmodule

// File: tb/tb_id_report_arbiter.sv
// Self-checking bench for id_report_arbiter: reset behaviour, a single
// request under backpressure, a table of round-robin transactions, a
// randomized phase against a queue-based reference model, and counter
// saturation.

module tb_id_report_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int SW   = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     gnt;
    logic [NREQ*DW-1:0]  id_in;
    logic [NREQ*DW-1:0]  p1_in;
    logic [NREQ*DW-1:0]  p2_in;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_id;
    logic [DW-1:0]       out_p1;
    logic [DW-1:0]       out_p2;
    logic [SW-1:0]       out_src;
    logic                busy;
    logic [15:0]         count;

    logic [DW-1:0] id_a [NREQ];
    logic [DW-1:0] p1_a [NREQ];
    logic [DW-1:0] p2_a [NREQ];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: search pointer and accepted-report count.
    int m_ptr   = 0;
    int m_count = 0;

    id_report_arbiter #(.NREQ(NREQ), .DW(DW), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .id_in     (id_in),
        .p1_in     (p1_in),
        .p2_in     (p2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_p1    (out_p1),
        .out_p2    (out_p2),
        .out_src   (out_src),
        .busy      (busy),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        id_in = '0;
        p1_in = '0;
        p2_in = '0;
        for (int k = 0; k < NREQ; k++) begin
            id_in[k*DW +: DW] = id_a[k];
            p1_in[k*DW +: DW] = p1_a[k];
            p2_in[k*DW +: DW] = p2_a[k];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference winner: build the service order starting at ptr and take
    // the first leaf in that order that is requesting.
    function automatic int model_pick(input int ptr, input logic [NREQ-1:0] r);
        int order[$];
        int w;
        w = -1;
        for (int k = ptr; k < NREQ; k++) order.push_back(k);
        for (int k = 0; k < ptr; k++) order.push_back(k);
        for (int j = 0; j < order.size(); j++) begin
            if (w < 0 && r[order[j]]) w = order[j];
        end
        return w;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // One full report, entered and left at a falling edge with the DUT in IDLE.
    task automatic run_report(input logic [NREQ-1:0] r, input logic [NREQ-1:0] r_after,
                              input int hold, input bit scramble, output int got_src);
        int w;
        logic [DW-1:0] e_id, e_p1, e_p2;
        w    = model_pick(m_ptr, r);
        e_id = id_a[w];
        e_p1 = p1_a[w];
        e_p2 = p2_a[w];
        req  = r;
        @(negedge clk);
        got_src = int'(out_src);
        check("grant_onehot", gnt, onehot(w));
        check("grant_valid", out_valid, 1'b1);
        check("grant_busy", busy, 1'b1);
        check("grant_src", out_src, w);
        check("grant_id", out_id, e_id);
        check("grant_p1", out_p1, e_p1);
        check("grant_p2", out_p2, e_p2);
        req = r_after;
        for (int h = 0; h < hold; h++) begin
            if (scramble) begin
                for (int k = 0; k < NREQ; k++) begin
                    id_a[k] = $urandom;
                    p1_a[k] = $urandom;
                    p2_a[k] = $urandom;
                end
                req = NREQ'($urandom) & ~onehot(w);
            end
            @(negedge clk);
            check("hold_gnt_low", gnt, '0);
            check("hold_valid", out_valid, 1'b1);
            check("hold_src", out_src, w);
            check("hold_id", out_id, e_id);
            check("hold_p1", out_p1, e_p1);
            check("hold_p2", out_p2, e_p2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        m_ptr = (w + 1) % NREQ;
        if (m_count < 65535) m_count++;
        check("accept_valid_low", out_valid, 1'b0);
        check("accept_busy_low", busy, 1'b0);
        check("accept_gnt_low", gnt, '0);
        check("accept_count", count, m_count);
        req = '0;
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] req_after;
        int              hold;
        int              exp_src;
    } vec_t;

    initial begin
        vec_t vecs [12];
        int   got;
        int   w;

        vecs[0]  = '{4'b1111, 4'b1110, 0, 0};
        vecs[1]  = '{4'b1111, 4'b1101, 0, 1};
        vecs[2]  = '{4'b1111, 4'b1011, 0, 2};
        vecs[3]  = '{4'b1111, 4'b0111, 0, 3};
        vecs[4]  = '{4'b1111, 4'b1110, 1, 0};
        vecs[5]  = '{4'b0100, 4'b0000, 2, 2};
        vecs[6]  = '{4'b0011, 4'b0010, 0, 0};
        vecs[7]  = '{4'b0010, 4'b0000, 0, 1};
        vecs[8]  = '{4'b1001, 4'b1000, 1, 3};
        vecs[9]  = '{4'b1000, 4'b0000, 0, 3};
        vecs[10] = '{4'b0110, 4'b0100, 0, 1};
        vecs[11] = '{4'b0001, 4'b0000, 0, 0};

        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            id_a[k] = DW'(100 + k);
            p1_a[k] = DW'(500 + k);
            p2_a[k] = DW'(600 + k);
        end

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_gnt", gnt, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", count, 16'd0);
        check("rst_src", out_src, '0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_no_gnt", gnt, '0);

        // Single request from leaf 2, then backpressure with input change.
        id_a[2] = 32'd6;
        p1_a[2] = 32'd502;
        p2_a[2] = 32'd503;
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        check("single_gnt", gnt, 4'b0100);
        check("single_valid", out_valid, 1'b1);
        check("single_src", out_src, 2);
        check("single_id", out_id, 32'd6);
        check("single_p1", out_p1, 32'd502);
        check("single_p2", out_p2, 32'd503);
        id_a[2] = 32'd99;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            check("bp_gnt_pulse", gnt, '0);
            check("bp_valid", out_valid, 1'b1);
            check("bp_id", out_id, 32'd6);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_count", count, 16'd1);
        check("bp_valid_low", out_valid, 1'b0);

        // Asynchronous reset while holding a report for leaf 1 with id 7.
        id_a[1] = 32'd7;
        p1_a[1] = 32'd71;
        p2_a[1] = 32'd72;
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        check("pre_rst_id", out_id, 32'd7);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_id", out_id, '0);
        check("async_rst_p1", out_p1, '0);
        check("async_rst_p2", out_p2, '0);
        check("async_rst_src", out_src, '0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_count", count, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        m_ptr   = 0;
        m_count = 0;
        for (int c = 0; c < 3; c++) begin
            out_ready = c[0];
            @(negedge clk);
            check("post_rst_idle_gnt", gnt, '0);
            check("post_rst_idle_valid", out_valid, 1'b0);
        end
        out_ready = 1'b0;

        // Table of round-robin transactions starting from ptr=0.
        for (int v = 0; v < 12; v++) begin
            run_report(vecs[v].req, vecs[v].req_after, vecs[v].hold, 1'b0, got);
            check($sformatf("table_src[%0d]", v), got, vecs[v].exp_src);
        end

        // Randomized traffic against the reference model, with idle gaps.
        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < NREQ; k++) begin
                id_a[k] = $urandom;
                p1_a[k] = $urandom;
                p2_a[k] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                req = '0;
                out_ready = 1'($urandom);
                @(negedge clk);
                out_ready = 1'b0;
                check("rand_idle_gnt", gnt, '0);
                check("rand_idle_valid", out_valid, 1'b0);
                check("rand_idle_count", count, m_count);
            end
            begin
                logic [NREQ-1:0] r;
                r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                w = model_pick(m_ptr, r);
                run_report(r, r & ~onehot(w), $urandom_range(0, 3), 1'b1, got);
            end
        end

        // Counter saturation: preload close to the limit, then report three times.
        force dut.count_q = 16'hFFFD;
        #1 release dut.count_q;
        m_count = 65533;
        @(negedge clk);
        check("sat_preload", count, 16'hFFFD);
        for (int s = 0; s < 3; s++) begin
            run_report(4'b0001, 4'b0000, 0, 1'b0, got);
        end
        check("sat_hold", count, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
